des_frame_loader: RTL and testbench

//  Byte-serial front end for the 16-round DES datapath. Assembles a header, an optional
//  64-bit key and a 64-bit data block from an 8-bit valid/ready stream. Drives plaintext/key/

---
 rtl/des_frame_loader_if.sv | 25 ++
 rtl/des_frame_loader.sv | 128 ++++++++++++
 tb/tb_des_frame_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/des_frame_loader_if.sv
// Byte stream, round-pipeline and result-port signals shared between the DES frame loader
// and its environment. The loader attaches through the slave modport.
interface des_frame_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic [63:0] key;
  logic        select;
  logic [63:0] dectext;
  logic [63:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  modport master (
    output in_data, in_valid, dectext, res_ready,
    input  in_ready, plaintext, key, select, res_data, res_valid, busy
  );

  modport slave (
    input  in_data, in_valid, dectext, res_ready,
    output in_ready, plaintext, key, select, res_data, res_valid, busy
  );
endinterface

// File: rtl/des_frame_loader.sv
// Byte-serial front end for the DES round pipeline: assembles header/key/data frames,
// waits out the pipeline latency and presents the captured result on a valid/ready port.
module des_frame_loader #(
  parameter int PIPE_LAT = 16
) (
  input  logic clk,
  input  logic rst,
  des_frame_loader_if.slave bus
);

  localparam int CW = $clog2(PIPE_LAT + 1);
  // Pipeline stages register at edges N+1..N+PIPE_LAT, so dectext is sampled one edge later.
  localparam logic [CW-1:0] LAT_END = CW'(PIPE_LAT);

  typedef enum logic [2:0] {S_HDR, S_KEY, S_DATA, S_RUN, S_OUT} state_t;

  state_t         state, state_nx;
  logic           in_ready_c;
  logic [2:0]     byte_cnt;
  logic [CW-1:0]  lat_cnt;
  logic [63:0]    key_sh;
  logic [63:0]    data_sh;
  logic [63:0]    key_q;
  logic [63:0]    plaintext_q;
  logic           select_q;
  logic [63:0]    res_data_q;
  logic           res_valid_q;
  logic           accept;
  logic           last_byte;

  assign accept    = bus.in_valid & in_ready_c;
  assign last_byte = accept && (byte_cnt == 3'd7);

  assign bus.in_ready  = in_ready_c;
  assign bus.plaintext = plaintext_q;
  assign bus.key       = key_q;
  assign bus.select    = select_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state != S_HDR);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_HDR;
    else      state <= state_nx;
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    case (state)
      S_HDR: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = bus.in_data[1] ? S_KEY : S_DATA;
      end
      S_KEY: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && byte_cnt == 3'd7) state_nx = S_DATA;
      end
      S_DATA: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && byte_cnt == 3'd7) state_nx = S_RUN;
      end
      S_RUN: begin
        if (lat_cnt == LAT_END) state_nx = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) state_nx = S_HDR;
      end
      default: state_nx = S_HDR;
    endcase
  end

  // Shadow registers are reset too, so a frame cut short by reset leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt    <= 3'd0;
      lat_cnt     <= '0;
      key_sh      <= 64'd0;
      data_sh     <= 64'd0;
      key_q       <= 64'd0;
      plaintext_q <= 64'd0;
      select_q    <= 1'b0;
      res_data_q  <= 64'd0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        S_HDR: begin
          if (accept) begin
            select_q <= bus.in_data[0];
            byte_cnt <= 3'd0;
          end
        end
        S_KEY: begin
          if (accept) begin
            key_sh   <= {key_sh[55:0], bus.in_data};
            byte_cnt <= byte_cnt + 3'd1;
            if (last_byte) key_q <= {key_sh[55:0], bus.in_data};
          end
        end
        S_DATA: begin
          if (accept) begin
            data_sh  <= {data_sh[55:0], bus.in_data};
            byte_cnt <= byte_cnt + 3'd1;
            if (last_byte) begin
              plaintext_q <= {data_sh[55:0], bus.in_data};
              lat_cnt     <= '0;
            end
          end
        end
        S_RUN: begin
          if (lat_cnt == LAT_END) begin
            res_data_q  <= bus.dectext;
            res_valid_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_frame_loader.sv
// Directed bench for des_frame_loader: a PIPE_LAT-deep stub pipeline returns known DES
// answers for the reference vectors and a simple invertible mix otherwise.
module tb_des_frame_loader;

  localparam int PIPE_LAT = 16;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_acc;
  int   res_cyc;
  logic [63:0] hold_data;

  des_frame_loader_if bus ();

  des_frame_loader #(.PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] stub_fn(input logic [63:0] pt, input logic [63:0] k,
                                          input logic sel);
    if (pt == P1 && k == K1 && !sel) return C1;
    if (pt == C1 && k == K1 && sel)  return P1;
    return pt ^ k ^ {64{sel}};
  endfunction

  logic [63:0] pipe [PIPE_LAT];
  always @(posedge clk) begin
    for (int i = PIPE_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= stub_fn(bus.plaintext, bus.key, bus.select);
  end
  assign bus.dectext = pipe[PIPE_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte, optionally after an idle gap; records the accepting edge in last_acc.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    if (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 64'd0, 64'd1);
    tick();
    last_acc     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input bit gaps);
    logic [63:0] t;
    t = w;
    for (int i = 0; i < 8; i++) begin
      send_byte(t[63:56], gaps ? bit'($urandom_range(0, 1)) : 1'b0);
      t = t << 8;
    end
  endtask

  task automatic wait_res();
    int guard = 0;
    while (!bus.res_valid && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("res_valid_timeout", 64'd0, 64'd1);
    res_cyc = cyc;
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;

    // 1: reset
    rst = 1'b0;
    repeat (3) tick();
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_key", bus.key, 64'd0);
    check("rst_plaintext", bus.plaintext, 64'd0);
    check("rst_res_data", bus.res_data, 64'd0);
    check("rst_select", 64'(bus.select), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 2: encrypt with key load; key must not move mid-load
    send_byte(8'h02, 1'b0);
    check("enc_busy_hdr", 64'(bus.busy), 64'd1);
    send_byte(8'h13, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h57, 1'b0); send_byte(8'h79, 1'b0);
    check("enc_key_midload", bus.key, 64'd0);
    send_byte(8'h9B, 1'b0); send_byte(8'hBC, 1'b0);
    send_byte(8'hDF, 1'b0); send_byte(8'hF1, 1'b0);
    check("enc_key_loaded", bus.key, K1);
    send_word(P1, 1'b0);
    check("enc_plaintext", bus.plaintext, P1);
    check("enc_select", 64'(bus.select), 64'd0);
    check("enc_run_in_ready", 64'(bus.in_ready), 64'd0);
    wait_res();
    check("enc_latency", 64'(res_cyc - last_acc), 64'(PIPE_LAT + 1));
    check("enc_res_data", bus.res_data, C1);

    // 4: backpressure on the result port, stray bytes ignored
    hold_data = bus.res_data;
    bus.in_data  = 8'h03;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_res_valid", 64'(bus.res_valid), 64'd1);
      check("bp_res_data", bus.res_data, hold_data);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    take_res();
    check("bp_busy_after", 64'(bus.busy), 64'd0);
    check("bp_res_valid_after", 64'(bus.res_valid), 64'd0);
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("bp_key_kept", bus.key, K1);

    // 3: decrypt reusing the stored key
    send_byte(8'h01, 1'b0);
    check("dec_select", 64'(bus.select), 64'd1);
    send_word(C1, 1'b0);
    check("dec_key_kept", bus.key, K1);
    check("dec_plaintext", bus.plaintext, C1);
    wait_res();
    check("dec_latency", 64'(res_cyc - last_acc), 64'(PIPE_LAT + 1));
    check("dec_res_data", bus.res_data, P1);
    take_res();

    // 5: encrypt with random stream gaps, res_ready held high -> one-cycle pulse
    send_byte(8'h02, 1'b1);
    send_word(K1, 1'b1);
    send_word(P1, 1'b1);
    bus.res_ready = 1'b1;
    wait_res();
    check("gap_latency", 64'(res_cyc - last_acc), 64'(PIPE_LAT + 1));
    check("gap_res_data", bus.res_data, C1);
    tick();
    check("gap_pulse_low", 64'(bus.res_valid), 64'd0);
    check("gap_busy_low", 64'(bus.busy), 64'd0);
    bus.res_ready = 1'b0;

    // 6: reset after the 5th key byte, then a key-reuse decrypt frame
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0); send_byte(8'hEE, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    check("mrst_key", bus.key, 64'd0);
    check("mrst_plaintext", bus.plaintext, 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    send_byte(8'h01, 1'b0);
    send_word(C1, 1'b0);
    check("mrst_key_zero", bus.key, 64'd0);
    wait_res();
    check("mrst_latency", 64'(res_cyc - last_acc), 64'(PIPE_LAT + 1));
    check("mrst_res_data", bus.res_data, 64'h7A17ECABF0F54BFA);
    take_res();
    check("mrst_done_busy", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
